twiddle_feeder: RTL
===================

TWIDDLE_FEEDER -- requirements
Module: twiddle_feeder

Interface
REQ-001: Parameters:
- LOG2N, default 4, log2 of FFT frame length N (N = 2^LOG2N, range 2..10).
- STRIDE, default 1, twiddle index step per sample for this butterfly stage (power of two, < N).
REQ-002: Ports, one per line:
- clk_i  input  1  single clock; all state on rising edge.
- reset_ni  input  1  asynchronous, active-low reset.
- enable_i  input  1  start/continue framing.
- s_valid_i  input  1  upstream sample valid.
- s_ready_o  output  1  feeder can accept a sample.
- s_data_i  input  50  complex sample {re[24:0], im[24:0]}, two's complement.
- s_last_i  input  1  marks last sample of a frame.
- m_ready_i  input  1  multiplier side can accept (tie high when unused).
- stage_o  output  50  sample to multiplier, {re[24:0], im[24:0]}.
- w_o  output  36  twiddle {re[17:0], im[17:0]}, Q1.17 two's complement.
- data_valid_o  output  1  stage_o/w_o valid.
- frame_err_o  output  1  one-cycle pulse on framing error.
- frame_cnt_o  output  16  completed frames, wraps at 65535 -> 0.
REQ-003: Reset is asynchronous assert, active-low, on reset_ni; one clock clk_i; no other clocks or gated clocks.

Function
REQ-004: Sample index counter k (LOG2N bits) increments on each accepted sample (s_valid_i && s_ready_o); it wraps from N-1 to 0.
REQ-005: Twiddle index t = (k * STRIDE) mod N; w_o = {round(131071*cos(2*pi*t/N)), round(-131071*sin(2*pi*t/N))}; table built at elaboration, no runtime trig.
REQ-006: Output register: on acceptance, stage_o <= s_data_i, w_o <= twiddle(k), data_valid_o <= 1 on the next edge; latency exactly 1 cycle.
REQ-007: s_ready_o = (state == RUN or DRAIN-not-yet-accepting-last) ... restated: s_ready_o = (state == RUN) && (!data_valid_o || m_ready_i); combinational from registered state.
REQ-008: data_valid_o clears after a cycle with data_valid_o && m_ready_i and no new acceptance; while data_valid_o && !m_ready_i, stage_o/w_o/data_valid_o hold stable.
REQ-009: FSM states IDLE, RUN, DRAIN:
- IDLE -> RUN when enable_i = 1.
- RUN -> DRAIN when a sample with s_last_i is accepted and enable_i = 0.
- DRAIN -> IDLE when data_valid_o = 0, or data_valid_o && m_ready_i.
- RUN stays in RUN otherwise.
REQ-010: Accepted s_last_i with k == N-1: frame_cnt_o increments; k wraps to 0.
REQ-011: Accepted s_last_i with k != N-1: frame_err_o pulses 1 cycle, k resets to 0, frame_cnt_o unchanged; sample still forwarded with twiddle(k).
REQ-012: Accepted sample at k == N-1 without s_last_i: frame_err_o pulses 1 cycle; k wraps to 0; frame_cnt_o unchanged.
REQ-013: enable_i deasserted mid-frame: RUN continues until frame end (REQ-009); no samples dropped.

Reset
REQ-014: While reset_ni = 0: state = IDLE, k = 0, data_valid_o = 0, s_ready_o = 0, frame_err_o = 0, frame_cnt_o = 0, stage_o = 0, w_o = 0.
REQ-015: Reset asserted mid-frame discards the in-flight output and partial frame; after release the first accepted sample uses k = 0.

Verification
REQ-016: N=16, STRIDE=1, m_ready_i=1, 16 samples streamed back-to-back with s_last_i on 16th -> w_o at k=0: {131071,0}; k=4: {0,-131071 (18'h20001)}; k=8: {-131071,0}; frame_cnt_o = 1; no frame_err_o.
REQ-017: STRIDE=4, k=1 -> t=4, w_o = {0,18'h20001}; k=2 -> {18'h20001,0}.
REQ-018: m_ready_i held 0 for 3 cycles with data_valid_o=1 -> stage_o/w_o stable; s_ready_o=0; no sample lost or duplicated.
REQ-019: s_last_i on 5th sample -> frame_err_o pulses one cycle; next accepted sample uses w_o {131071,0}; frame_cnt_o unchanged.
REQ-020: enable_i dropped after sample 3 -> remaining 13 accepted, state reaches IDLE after last output handshake, s_ready_o = 0 afterwards.
REQ-021: reset_ni pulsed low at sample 7 -> all outputs zero asynchronously; restart gives k=0 twiddle {131071,0}.

Source files
------------

// File: rtl/twiddle_feeder.sv
// Twiddle feeder: frames a complex sample stream, pairs each accepted sample
// with its FFT twiddle factor and forwards both through a one-deep register.
module twiddle_feeder #(
    parameter int unsigned LOG2N  = 4,
    parameter int unsigned STRIDE = 1
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        enable_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [49:0] s_data_i,
    input  logic        s_last_i,
    input  logic        m_ready_i,
    output logic [49:0] stage_o,
    output logic [35:0] w_o,
    output logic        data_valid_o,
    output logic        frame_err_o,
    output logic [15:0] frame_cnt_o
);
    localparam int unsigned N  = 1 << LOG2N;
    localparam int unsigned TW = 36;
    localparam int unsigned CW = 16;
    localparam real         PI = 3.14159265358979323846;
    localparam logic [LOG2N-1:0] K_LAST = LOG2N'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LOG2N-1:0] k_q;
    logic [TW-1:0]    tw_rom [N];
    logic             accept_c;
    logic             k_end_c;

    // Twiddle ROM per sample index, evaluated at elaboration (round half away from zero)
    for (genvar i = 0; i < int'(N); i++) begin : g_tw
        localparam int unsigned T  = (i * STRIDE) % N;
        localparam real         AN = 2.0 * PI * $itor(T) / $itor(N);
        localparam real         CR = 131071.0 * $cos(AN);
        localparam real         SR = -131071.0 * $sin(AN);
        localparam int          CI = (CR >= 0.0) ? $rtoi(CR + 0.5) : $rtoi(CR - 0.5);
        localparam int          SI = (SR >= 0.0) ? $rtoi(SR + 0.5) : $rtoi(SR - 0.5);
        assign tw_rom[i] = {18'(CI), 18'(SI)};
    end

    // Upstream handshake: accept only while running and the output slot frees up
    assign s_ready_o = (state_q == RUN) && (!data_valid_o || m_ready_i);
    assign accept_c  = s_valid_i && s_ready_o;
    assign k_end_c   = (k_q == K_LAST);

    // Next-state logic; a disable only takes effect at the end of a frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (accept_c && s_last_i && !enable_i) state_d = DRAIN;
            DRAIN:   if (!data_valid_o || m_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample index, output register and framing status
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            k_q          <= '0;
            stage_o      <= '0;
            w_o          <= '0;
            data_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            frame_err_o <= 1'b0;
            if (accept_c) begin
                stage_o      <= s_data_i;
                w_o          <= tw_rom[k_q];
                data_valid_o <= 1'b1;
                k_q          <= (s_last_i || k_end_c) ? '0 : k_q + LOG2N'(1);
                // A frame is good only when last and the final index coincide
                frame_err_o  <= s_last_i ^ k_end_c;
                if (s_last_i && k_end_c) begin
                    frame_cnt_o <= frame_cnt_o + CW'(1);
                end
            end else if (data_valid_o && m_ready_i) begin
                data_valid_o <= 1'b0;
            end
        end
    end

endmodule
